bdi_line_decompressor: RTL
==========================

# bdi_line_decompressor

Parametrised, pipelined Base-Delta-Immediate cache-line decompressor with valid/ready flow control on both sides. It accepts one compressed line per cycle with a binary encoding tag and a per-element immediate mask. It produces the reconstructed line two cycles later with sign-extended deltas, zero-line and repeated-value modes, reserved-encoding error flagging and running statistics counters. It sits between the compressed cache data array and the fill/read-return path, replacing the single-width one-hot-controlled decompressor.

## Interface
- LINE_BYTES, 32, uncompressed line size in bytes; legal values 16, 32, 64; W = LINE_BYTES*8
- NMAX, LINE_BYTES/2, derived localparam: maximum element count, reached by base-2 encodings
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  compressed line present
- in_ready  out  1  block accepts the line this cycle
- in_enc  in  4  encoding tag (see Operation)
- in_imm  in  NMAX  immediate mask: bit i=1 means element i is delta-from-zero
- in_data  in  W  compressed payload, LSB-aligned
- out_valid  out  1  decompressed line present
- out_ready  in  1  consumer accepts the line this cycle
- out_data  out  W  decompressed line
- out_err  out  1  line carried a reserved encoding
- line_count  out  32  lines delivered, saturating
- err_count  out  16  erroneous lines delivered, saturating

## Operation
- Encodings: 0 raw (out = in_data); 1 zeros; 2 repeat (in_data[63:0] replicated LINE_BYTES/8 times); 3 B8D1; 4 B8D2; 5 B8D4; 6 B4D1; 7 B4D2; 8 B2D1. Base size B bytes, delta size D bytes.
- Encodings 9–15 are reserved: out_data = in_data, out_err = 1.
- Element count N = LINE_BYTES/B. Base occupies in_data[8B-1:0]. The delta for element i (1..N-1) occupies in_data[8B+8D(i-1) +: 8D].
- Element 0 = base. Element i = (in_imm[i] ? 0 : base) + sext(delta_i), where sext is two's-complement extension to 8B bits and the sum is taken modulo 2^(8B).
- in_imm[0] is ignored. in_imm bits at or above N are ignored. Payload bits beyond the used region are ignored.
- Element i is placed at out_data[8B*i +: 8B].
- Stage 1: register enc, imm and data on input handshake, and decode enc to mode and error flags.
- Stage 2: compute all elements in parallel, register out_data and out_err, and set out_valid.
- Both stages advance when !out_valid || out_ready. in_ready = !s1_valid || advance. No combinational path from in_valid to in_ready.
- On an output handshake (out_valid && out_ready): line_count += 1, saturating at 2^32-1. If out_err, also err_count += 1, saturating at 2^16-1.

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0, line_count 0, err_count 0, s1_valid 0. in_ready is 1 during and after reset.
- Latency: a line accepted at edge T has out_valid=1 after edge T+2 when unstalled. Throughput is one line per cycle.
- Stall: while out_valid && !out_ready, out_data and out_err hold stable. At most one additional line is buffered in stage 1, after which in_ready=0.
- Simultaneous output handshake and input handshake in the same cycle: both complete, pipeline stays full, no bubble.
- Reset asserted mid-operation: all valids clear immediately (asynchronously). In-flight lines are discarded and counters zero. The first cycle after deassertion accepts input.
- in_enc, in_imm and in_data are sampled only on an input handshake.

## Test plan
- B8D1, LINE_BYTES=32: base 0x1000, deltas 0x05/0xFF/0x80, imm 0 → out_data = {0x0F80, 0x0FFF, 0x1005, 0x1000} as 64-bit elements, out_valid 2 cycles after accept, out_err 0.
- B4D1 with immediate: base 0x12345678, in_imm[1]=1, delta1=0xFE, other deltas 0x01 → element1 = 0xFFFFFFFE, elements 2..7 = 0x12345679.
- Modes: enc=1 with random data → all-zero line. enc=2, in_data[63:0]=0xDEADBEEF01234567 → that value in all 4 slots. enc=0 → out = in.
- Reserved enc=0xF with random data → out_data = in_data, out_err=1; after handshake err_count=1, line_count=1.
- Backpressure: out_ready=0, offer 3 back-to-back lines → first held stable on output, second in stage 1, in_ready=0 for third. Releasing out_ready delivers all three in order, one per cycle.
- Reset after 5 lines with two in flight → outputs and counters zero at once; a new line after release appears 2 cycles later with line_count=1 after its handshake.

Source files
------------

// File: rtl/bdi_line_decompressor.sv
// Two-stage Base-Delta-Immediate cache-line decompressor.
// Stage 1 captures the compressed line and decodes the encoding tag;
// stage 2 expands every element in parallel and holds the result until the
// consumer takes it.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and payload steady
// until the transfer; in_ready depends only on internal state, never on in_valid.
module bdi_line_decompressor #(
  parameter  int LINE_BYTES = 32,
  localparam int W          = LINE_BYTES * 8,
  localparam int NMAX       = LINE_BYTES / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_enc,
  input  logic [NMAX-1:0] in_imm,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_err,
  output logic [31:0]     line_count,
  output logic [15:0]     err_count
);

  localparam int REP = LINE_BYTES / 8;

  typedef enum logic [1:0] {
    M_RAW  = 2'd0,
    M_ZERO = 2'd1,
    M_REP  = 2'd2,
    M_BD   = 2'd3
  } mode_t;

  // Stage 1 state
  logic            r_s1_valid;
  mode_t           r_mode;
  logic [2:0]      r_cfg;
  logic            r_s1_err;
  logic [NMAX-1:0] r_imm;
  logic [W-1:0]    r_data;

  // Stage 2 / output state
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic            r_out_err;
  logic [31:0]     r_line_count;
  logic [15:0]     r_err_count;

  logic            w_advance;
  logic            w_in_hs;
  logic            w_out_hs;
  mode_t           w_mode;
  logic [2:0]      w_cfg;
  logic            w_dec_err;
  logic [W-1:0]    w_result;
  logic [W-1:0]    w_bd [8];

  assign w_advance  = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_advance;
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_out_valid && out_ready;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_err    = r_out_err;
  assign line_count = r_line_count;
  assign err_count  = r_err_count;

  // Decode the tag into a mode plus a base/delta configuration index (enc-3)
  always_comb begin
    w_mode    = M_RAW;
    w_cfg     = 3'd0;
    w_dec_err = 1'b0;
    case (in_enc)
      4'd0:    w_mode = M_RAW;
      4'd1:    w_mode = M_ZERO;
      4'd2:    w_mode = M_REP;
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        w_mode = M_BD;
        w_cfg  = 3'(in_enc - 4'd3);
      end
      default: w_dec_err = 1'b1;
    endcase
  end

  // One expander per base/delta configuration; all run in parallel on stage 1
  for (genvar c = 0; c < 6; c++) begin : g_cfg
    localparam int B = (c < 3) ? 8 : (c < 5) ? 4 : 2;
    localparam int D = (c == 0 || c == 3 || c == 5) ? 1 : (c == 1 || c == 4) ? 2 : 4;
    localparam int N = LINE_BYTES / B;
    logic [8*B-1:0] w_base;
    logic [W-1:0]   w_line;
    assign w_base            = r_data[8*B-1:0];
    assign w_line[8*B-1:0]   = w_base;
    for (genvar i = 1; i < N; i++) begin : g_el
      logic [8*D-1:0] w_delta;
      assign w_delta = r_data[8*B + 8*D*(i-1) +: 8*D];
      assign w_line[8*B*i +: 8*B] = (r_imm[i] ? {(8*B){1'b0}} : w_base)
                                  + {{(8*B-8*D){w_delta[8*D-1]}}, w_delta};
    end
    assign w_bd[c] = w_line;
  end
  assign w_bd[6] = r_data;
  assign w_bd[7] = r_data;

  // Select the reconstructed line for the decoded mode
  always_comb begin
    w_result = r_data;
    case (r_mode)
      M_ZERO:  w_result = '0;
      M_REP:   w_result = {REP{r_data[63:0]}};
      M_BD:    w_result = w_bd[r_cfg];
      default: w_result = r_data;
    endcase
  end

  // Stage 1: capture the compressed line on an input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_mode     <= M_RAW;
      r_cfg      <= 3'd0;
      r_s1_err   <= 1'b0;
      r_imm      <= '0;
      r_data     <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_hs) begin
        r_mode   <= w_mode;
        r_cfg    <= w_cfg;
        r_s1_err <= w_dec_err;
        r_imm    <= in_imm;
        r_data   <= in_data;
      end
    end
  end

  // Stage 2: register the expanded line; hold it while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_result;
        r_out_err  <= r_s1_err;
      end
    end
  end

  // Saturating delivery statistics, counted on output handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_count <= '0;
      r_err_count  <= '0;
    end else if (w_out_hs) begin
      if (r_line_count != '1) r_line_count <= r_line_count + 32'd1;
      if (r_out_err && (r_err_count != '1)) r_err_count <= r_err_count + 16'd1;
    end
  end

endmodule
